// File: rtl/bus_pkg.sv
// Shared bus-fabric definitions: arbitration policy codes, arbiter FSM states
// and a one-hot to index encoder used by the arbiters.
package bus_pkg;

  localparam int ARB_FIXED   = 0;
  localparam int ARB_RR      = 1;
  localparam int MAX_MASTERS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // OR-reduction encoder: exact for one-hot input, no priority chain.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker. In round-robin mode the search starts
// at start_i and wraps; in fixed mode it always starts at index 0.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic          mode_i,
  output logic [N-1:0]  win_o
);

  always_comb begin
    logic found;
    int   base;
    int   idx;
    win_o = '0;
    found = 1'b0;
    base  = mode_i ? int'(start_i) : 0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = base + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master Wishbone arbiter for one shared slave: fixed-priority or round-robin
// grant, optional beat-limit preemption, one-hot AND-OR datapath muxing.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NMASTERS = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MODE     = 1,
  parameter int MAXBEATS = 8
) (
  input  logic                     sysclock,
  input  logic                     rst_i,
  input  logic [NMASTERS-1:0]      m_cyc_i,
  input  logic [NMASTERS-1:0]      m_stb_i,
  input  logic [NMASTERS-1:0]      m_we_i,
  input  logic [NMASTERS*AW-1:0]   m_adr_i,
  input  logic [NMASTERS*DW-1:0]   m_dat_i,
  input  logic [NMASTERS*DW/8-1:0] m_sel_i,
  output logic [NMASTERS-1:0]      m_ack_o,
  output logic [DW-1:0]            m_dat_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [AW-1:0]            s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  output logic [DW/8-1:0]          s_sel_o,
  input  logic [DW-1:0]            s_dat_i,
  input  logic                     s_ack_i,
  output logic [NMASTERS-1:0]      gnt_o,
  output logic                     busy_o
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(NMASTERS);
  localparam int CW = $clog2(MAXBEATS + 2);
  localparam logic          MODE_RR   = 1'(MODE == ARB_RR);
  localparam logic          LIMIT_EN  = 1'(MAXBEATS > 0);
  localparam logic [CW-1:0] LAST_BEAT = CW'((MAXBEATS > 0) ? MAXBEATS - 1 : 0);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAXBEATS);
  localparam logic [IW-1:0] PTR_LAST  = IW'(NMASTERS - 1);

  arb_state_t           state_q;
  logic [NMASTERS-1:0]  gnt_q;
  logic [CW-1:0]        beat_q;
  logic [IW-1:0]        ptr_q;

  logic [NMASTERS-1:0]  win;
  logic [IW-1:0]        start_idx;
  logic                 owner_cyc;
  logic                 others_req;
  logic                 preempt;
  logic                 tenure_end;

  assign start_idx = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

  rr_pick #(
    .N  (NMASTERS),
    .IW (IW)
  ) u_pick (
    .req_i   (m_cyc_i),
    .start_i (start_idx),
    .mode_i  (MODE_RR),
    .win_o   (win)
  );

  assign owner_cyc  = |(gnt_q & m_cyc_i);
  assign others_req = |(m_cyc_i & ~gnt_q);
  // Preemption only fires on an acked beat, so no beat is ever split.
  assign preempt    = LIMIT_EN && s_ack_i && (beat_q == LAST_BEAT) && others_req;
  // Owner drop and preemption on the same edge collapse into one release.
  assign tenure_end = !owner_cyc || preempt;

  always_ff @(posedge sysclock or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      beat_q  <= '0;
      ptr_q   <= PTR_LAST;
    end else begin
      case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            state_q <= OWNED;
            gnt_q   <= win;
            if (MODE_RR) ptr_q <= IW'(onehot_to_idx(MAX_MASTERS'(win)));
          end
        end
        OWNED: begin
          if (tenure_end) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            beat_q  <= '0;
          end else if (s_ack_i && (beat_q != MAX_CNT)) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          beat_q  <= '0;
        end
      endcase
    end
  end

  // gnt_q is zero outside OWNED, so every slave-side term is naturally idle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      s_adr_o = s_adr_o | (m_adr_i[i*AW +: AW] & {AW{gnt_q[i]}});
      s_dat_o = s_dat_o | (m_dat_i[i*DW +: DW] & {DW{gnt_q[i]}});
      s_sel_o = s_sel_o | (m_sel_i[i*SW +: SW] & {SW{gnt_q[i]}});
    end
  end

  assign s_cyc_o = |(gnt_q & m_cyc_i);
  assign s_stb_o = |(gnt_q & m_cyc_i & m_stb_i);
  assign s_we_o  = |(gnt_q & m_cyc_i & m_we_i);
  assign m_ack_o = {NMASTERS{s_ack_i}} & gnt_q & m_cyc_i;
  assign m_dat_o = rst_i ? '0 : s_dat_i;
  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q == OWNED);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: one round-robin instance with an 8-beat
// limit and one fixed-priority instance without a limit, sharing all inputs.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              sysclock;
  logic              rst_i;
  logic [N-1:0]      m_cyc_i;
  logic [N-1:0]      m_stb_i;
  logic [N-1:0]      m_we_i;
  logic [N*AW-1:0]   m_adr_i;
  logic [N*DW-1:0]   m_dat_i;
  logic [N*SW-1:0]   m_sel_i;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i;

  logic [N-1:0]  rr_m_ack, fx_m_ack;
  logic [DW-1:0] rr_m_dat, fx_m_dat;
  logic          rr_s_cyc, rr_s_stb, rr_s_we, fx_s_cyc, fx_s_stb, fx_s_we;
  logic [AW-1:0] rr_s_adr, fx_s_adr;
  logic [DW-1:0] rr_s_dat, fx_s_dat;
  logic [SW-1:0] rr_s_sel, fx_s_sel;
  logic [N-1:0]  rr_gnt, fx_gnt;
  logic          rr_busy, fx_busy;

  int tests_run;
  int tests_failed;
  int acks0;

  bus_arbiter_rr #(.NMASTERS(N), .AW(AW), .DW(DW), .MODE(1), .MAXBEATS(8)) u_rr (
    .sysclock (sysclock), .rst_i (rst_i),
    .m_cyc_i (m_cyc_i), .m_stb_i (m_stb_i), .m_we_i (m_we_i),
    .m_adr_i (m_adr_i), .m_dat_i (m_dat_i), .m_sel_i (m_sel_i),
    .m_ack_o (rr_m_ack), .m_dat_o (rr_m_dat),
    .s_cyc_o (rr_s_cyc), .s_stb_o (rr_s_stb), .s_we_o (rr_s_we),
    .s_adr_o (rr_s_adr), .s_dat_o (rr_s_dat), .s_sel_o (rr_s_sel),
    .s_dat_i (s_dat_i), .s_ack_i (s_ack_i),
    .gnt_o (rr_gnt), .busy_o (rr_busy)
  );

  bus_arbiter_rr #(.NMASTERS(N), .AW(AW), .DW(DW), .MODE(0), .MAXBEATS(0)) u_fx (
    .sysclock (sysclock), .rst_i (rst_i),
    .m_cyc_i (m_cyc_i), .m_stb_i (m_stb_i), .m_we_i (m_we_i),
    .m_adr_i (m_adr_i), .m_dat_i (m_dat_i), .m_sel_i (m_sel_i),
    .m_ack_o (fx_m_ack), .m_dat_o (fx_m_dat),
    .s_cyc_o (fx_s_cyc), .s_stb_o (fx_s_stb), .s_we_o (fx_s_we),
    .s_adr_o (fx_s_adr), .s_dat_o (fx_s_dat), .s_sel_o (fx_s_sel),
    .s_dat_i (s_dat_i), .s_ack_i (s_ack_i),
    .gnt_o (fx_gnt), .busy_o (fx_busy)
  );

  // Clock / reset
  initial sysclock = 1'b0;
  always #5 sysclock = ~sysclock;

  task automatic step();
    @(posedge sysclock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin tenure of two acks, owner drops cyc, all four re-request.
  task automatic rr_tenure(input int owner, input logic [N-1:0] exp_next);
    logic [N-1:0] own_oh;
    own_oh = N'(1) << owner;
    s_ack_i = 1'b1;
    #1;
    check("rr_ack_beat1", rr_m_ack, own_oh);
    step();
    #1;
    check("rr_ack_beat2", rr_m_ack, own_oh);
    step();
    m_cyc_i[owner] = 1'b0;
    s_ack_i = 1'b0;
    #1;
    check("rr_gnt_held_until_edge", rr_gnt, own_oh);
    step();
    #1;
    check("rr_idle_gap_gnt", rr_gnt, '0);
    check("rr_idle_gap_busy", rr_busy, 1'b0);
    m_cyc_i = 4'b1111;
    step();
    #1;
    check("rr_next_grant", rr_gnt, exp_next);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    acks0        = 0;
    rst_i   = 1'b1;
    m_cyc_i = 4'b1111;
    m_stb_i = 4'b1111;
    m_we_i  = '0;
    for (int i = 0; i < N; i++) begin
      m_adr_i[i*AW +: AW] = 32'h1000_0000 + 32'(i) * 32'h100;
      m_dat_i[i*DW +: DW] = 32'hA000_0000 + 32'(i);
      m_sel_i[i*SW +: SW] = 4'(1 << i);
    end
    m_sel_i[1*SW +: SW] = 4'b0110;
    s_dat_i = 32'h1234_5678;
    s_ack_i = 1'b1;

    // Reset with every master requesting
    step();
    step();
    check("reset_gnt", rr_gnt, '0);
    check("reset_s_cyc", rr_s_cyc, 1'b0);
    check("reset_busy", rr_busy, 1'b0);
    check("reset_m_ack", rr_m_ack, '0);
    check("reset_m_dat", rr_m_dat, '0);
    rst_i   = 1'b0;
    s_ack_i = 1'b0;
    step();
    check("first_grant_rr", rr_gnt, 4'b0001);
    check("first_grant_fx", fx_gnt, 4'b0001);
    check("first_grant_s_cyc", rr_s_cyc, 1'b1);
    check("first_grant_busy", rr_busy, 1'b1);

    // Round-robin fairness 0,1,2,3,0
    rr_tenure(0, 4'b0010);
    rr_tenure(1, 4'b0100);
    rr_tenure(2, 4'b1000);
    rr_tenure(3, 4'b0001);

    // Preemption: master 0 streams with master 2 waiting
    m_cyc_i = 4'b0101;
    acks0   = 0;
    for (int k = 1; k <= 8; k++) begin
      s_ack_i = 1'b1;
      #1;
      check("pre_ack_m0", rr_m_ack, 4'b0001);
      if (rr_m_ack[0]) acks0++;
      step();
      #1;
      check("pre_gnt_after_ack", rr_gnt, (k < 8) ? 4'b0001 : 4'b0000);
    end
    #1;
    check("pre_no_stray_ack", rr_m_ack, '0);
    check("pre_idle_busy", rr_busy, 1'b0);
    step();
    check("pre_m2_granted", rr_gnt, 4'b0100);
    s_ack_i = 1'b1;
    step();
    step();
    m_cyc_i = 4'b0001;
    s_ack_i = 1'b0;
    step();
    check("pre_m2_release", rr_gnt, '0);
    step();
    check("pre_m0_regrant", rr_gnt, 4'b0001);
    for (int k = 1; k <= 12; k++) begin
      s_ack_i = 1'b1;
      #1;
      if (rr_m_ack[0]) acks0++;
      step();
    end
    check("pre_m0_not_preempted_alone", rr_gnt, 4'b0001);
    check("pre_total_beats", 64'(acks0), 64'd20);
    m_cyc_i = '0;
    s_ack_i = 1'b0;
    step();
    check("pre_final_release", rr_gnt, '0);

    // Owner drops cyc on the same edge as its 8th ack, master 0 waiting
    m_cyc_i = 4'b0101;
    step();
    check("sim_m2_granted", rr_gnt, 4'b0100);
    for (int k = 1; k <= 7; k++) begin
      s_ack_i = 1'b1;
      step();
    end
    check("sim_gnt_after_7", rr_gnt, 4'b0100);
    m_cyc_i = 4'b0001;
    #1;
    check("sim_no_ack_cyc_low", rr_m_ack, '0);
    step();
    s_ack_i = 1'b0;
    #1;
    check("sim_single_release_gnt", rr_gnt, '0);
    check("sim_single_release_busy", rr_busy, 1'b0);
    step();
    check("sim_next_grant", rr_gnt, 4'b0001);
    m_cyc_i = '0;
    step();
    step();

    // Routing: master 1 read while 0 and 2 hold cyc
    m_cyc_i = 4'b0111;
    m_stb_i = 4'b0111;
    step();
    check("route_gnt", rr_gnt, 4'b0010);
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("route_m_ack", rr_m_ack, 4'b0010);
    check("route_s_adr", rr_s_adr, 32'h1000_0100);
    check("route_s_sel", rr_s_sel, 4'b0110);
    check("route_s_dat", rr_s_dat, 32'hA000_0001);
    check("route_m_dat", rr_m_dat, 32'hDEAD_BEEF);
    check("route_s_we_read", rr_s_we, 1'b0);
    check("route_s_stb", rr_s_stb, 1'b1);
    m_we_i = 4'b0010;
    #1;
    check("route_s_we_write", rr_s_we, 1'b1);
    m_stb_i[1] = 1'b0;
    #1;
    check("route_stb_follows_owner", rr_s_stb, 1'b0);
    m_stb_i = 4'b1111;
    m_we_i  = '0;
    m_cyc_i = '0;
    s_ack_i = 1'b0;
    step();

    // Fixed priority, no beat limit
    rst_i = 1'b1;
    step();
    rst_i   = 1'b0;
    m_cyc_i = 4'b1010;
    step();
    check("fx_m1_first", fx_gnt, 4'b0010);
    s_ack_i = 1'b1;
    step();
    m_cyc_i = 4'b1000;
    s_ack_i = 1'b0;
    step();
    check("fx_m1_release", fx_gnt, '0);
    step();
    check("fx_m3_granted", fx_gnt, 4'b1000);
    m_cyc_i = 4'b1001;
    for (int k = 1; k <= 10; k++) begin
      s_ack_i = 1'b1;
      step();
    end
    check("fx_m3_not_preempted", fx_gnt, 4'b1000);
    check("fx_busy_owned", fx_busy, 1'b1);
    m_cyc_i = 4'b0001;
    s_ack_i = 1'b0;
    step();
    check("fx_m3_release", fx_gnt, '0);
    step();
    check("fx_m0_granted", fx_gnt, 4'b0001);

    // Asynchronous reset mid-tenure with a pending ack
    s_ack_i = 1'b1;
    #1;
    check("async_pre_ack", fx_m_ack, 4'b0001);
    rst_i = 1'b1;
    #1;
    check("async_gnt", fx_gnt, '0);
    check("async_s_cyc", fx_s_cyc, 1'b0);
    check("async_s_stb", fx_s_stb, 1'b0);
    check("async_m_ack", fx_m_ack, '0);
    check("async_busy", fx_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
